rx_ctrl_fsm: RTL and testbench

RX_CTRL_FSM -- requirements
Module: rx_ctrl_fsm

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/rx_edge_bit_cnt.sv | 42 ++++
 rtl/rx_ctrl_fsm.sv | 128 ++++++++++++
 tb/tb_rx_ctrl_fsm.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive controller (UART_RX_PARITY_EN adds the PARITY state)
package uart_rx_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/rx_edge_bit_cnt.sv
// rtl/rx_edge_bit_cnt.sv - oversample edge counter and data bit counter for the receive controller
module rx_edge_bit_cnt
    import uart_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] prescale,
    input  logic       load1,
    input  logic       clear,
    input  logic       run,
    input  logic       bit_inc,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       bit_end
);

    // The last oversample edge of the current bit; sampled_bit is only trusted here.
    assign bit_end = (edge_cnt == (prescale - 6'd1));

    // Edge count wraps each bit; bit count restarts with every new frame and saturates at a full byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= 4'd0;
        end else begin
            if (clear) begin
                edge_cnt <= 6'd0;
            end else if (load1) begin
                edge_cnt <= 6'd1;
            end else if (run) begin
                edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
            end

            if (clear || load1) begin
                bit_cnt <= 4'd0;
            end else if (bit_inc && (bit_cnt < 4'(DATA_WIDTH))) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/rx_ctrl_fsm.sv
// rtl/rx_ctrl_fsm.sv - UART receive control FSM; define UART_RX_PARITY_EN to receive a parity bit
module rx_ctrl_fsm
    import uart_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Rx_IN,
    input  logic [5:0] Prescale,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic       sampled_bit,
    output logic       dat_samp_en,
    output logic [5:0] edge_cnt,
    output logic [7:0] P_DATA,
    output logic       data_valid,
    output logic       par_err,
    output logic       stp_err
);

    rx_state_e  state;
    logic [3:0] bit_cnt;
    logic       bit_end;
    logic       load1;
    logic       clear;
    logic       run;
    logic       bit_inc;

`ifdef UART_RX_PARITY_EN
    logic par_err_q;
    assign par_err = par_err_q;
`else
    logic unused_par_ports;
    assign unused_par_ports = PAR_EN ^ PAR_TYP;
    assign par_err = 1'b0;
`endif

    rx_edge_bit_cnt u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .prescale (Prescale),
        .load1    (load1),
        .clear    (clear),
        .run      (run),
        .bit_inc  (bit_inc),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end)
    );

    // Counter controls: load on start detect, clear when the frame ends or the start bit was a glitch.
    always_comb begin
        load1   = (state == ST_IDLE) && !Rx_IN;
        clear   = bit_end && (((state == ST_START) && sampled_bit) || (state == ST_STOP));
        run     = (state != ST_IDLE);
        bit_inc = (state == ST_DATA) && bit_end;
    end

    // Frame sequencing with registered sampler enable, data, error flags and valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            dat_samp_en <= 1'b0;
            P_DATA      <= 8'h00;
            data_valid  <= 1'b0;
            stp_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!Rx_IN) begin
                        state       <= ST_START;
                        dat_samp_en <= 1'b1;
                        stp_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_err_q   <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        if (sampled_bit) begin
                            state       <= ST_IDLE;
                            dat_samp_en <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        P_DATA <= {sampled_bit, P_DATA[7:1]};
                        if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PAR_EN ? ST_PARITY : ST_STOP;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        par_err_q <= ((^P_DATA) ^ (PAR_TYP == PAR_ODD)) != sampled_bit;
                        state     <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        stp_err     <= ~sampled_bit;
                        data_valid  <= sampled_bit && !par_err;
                        dat_samp_en <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    dat_samp_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_ctrl_fsm.sv
// tb/tb_rx_ctrl_fsm.sv - randomized self-checking bench for rx_ctrl_fsm against a frame-level model
module tb_rx_ctrl_fsm;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Rx_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         valid_cnt = 0;
    int         valid_cyc = 0;
    logic [7:0] valid_data = 8'h00;
    logic [7:0] exp_pdata  = 8'h00;

    rx_ctrl_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Rx_IN       (Rx_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled_bit (sampled_bit),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            valid_cnt  = valid_cnt + 1;
            valid_data = P_DATA;
            valid_cyc  = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        Rx_IN = 1'b1;
        sampled_bit = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // glitch_len > 0: start bit held low only that many cycles. abort_at >= 0: reset pulse at that cycle.
    task automatic send_frame(input logic [5:0] ps, input logic [7:0] data, input bit pen, input bit ptyp,
                              input bit bad_par, input bit stop_bit, input int glitch_len, input int abort_at);
        bit par_on;
        bit bits[$];
        bit b;
        bit good;
        int total;
        int v0;
        int c0;
        int psi;
        bit aborted;
        psi     = int'(ps);
        par_on  = PAR_BUILD && pen;
        aborted = 1'b0;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (par_on) bits.push_back((^data) ^ ptyp ^ bad_par);
        bits.push_back(stop_bit);
        total = (glitch_len > 0) ? psi : bits.size() * psi;
        Prescale = ps;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        v0 = valid_cnt;
        c0 = cyc;
        for (int j = 0; j <= total; j++) begin
            if (j < total) begin
                b = bits[j / psi];
                if (glitch_len > 0 && j >= glitch_len) b = 1'b1;
            end else begin
                b = 1'b1;
            end
            Rx_IN = b;
            sampled_bit = b;
            if (j == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_edge_cnt", 32'(edge_cnt), 32'd0);
                check("abort_samp_en", 32'(dat_samp_en), 32'd0);
                check("abort_pdata", 32'(P_DATA), 32'd0);
                check("abort_valid", 32'(data_valid), 32'd0);
                check("abort_flags", {30'd0, par_err, stp_err}, 32'd0);
                rst_n = 1'b1;
                exp_pdata = 8'h00;
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
            check("edge_cnt", 32'(edge_cnt), 32'(j % psi));
            check("samp_en", 32'(dat_samp_en), 32'((j >= 1) && (j < total)));
            @(posedge clk);
            #1;
        end
        idle(2);
        good = !aborted && (glitch_len == 0) && stop_bit && !(par_on && bad_par);
        check("valid_count", 32'(valid_cnt - v0), 32'(good));
        if (!aborted && glitch_len == 0) begin
            exp_pdata = data;
            check("stp_err", 32'(stp_err), 32'(!stop_bit));
            check("par_err", 32'(par_err), 32'(par_on && bad_par));
        end else begin
            check("flags_clear", {30'd0, par_err, stp_err}, 32'd0);
        end
        check("p_data", 32'(P_DATA), 32'(exp_pdata));
        if (good) begin
            check("latency", 32'(valid_cyc - c0), 32'(total));
            check("valid_data", 32'(valid_data), 32'(data));
        end
    endtask

    initial begin
        logic [5:0] ps_tab [3];
        ps_tab[0] = 6'd8;
        ps_tab[1] = 6'd16;
        ps_tab[2] = 6'd32;
        rst_n = 1'b0;
        Rx_IN = 1'b1;
        sampled_bit = 1'b1;
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        check("rst_samp_en", 32'(dat_samp_en), 32'd0);
        check("rst_pdata", 32'(P_DATA), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_flags", {30'd0, par_err, stp_err}, 32'd0);
        rst_n = 1'b1;
        idle(3);

        send_frame(6'd8, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
        idle(1);
        send_frame(6'd16, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 0, -1);
        send_frame(6'd16, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 0, -1);
        send_frame(6'd16, 8'hC4, 1'b0, 1'b0, 1'b0, 1'b1, 2, -1);
        send_frame(6'd8, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        send_frame(6'd8, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
        send_frame(6'd16, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0, 5 * 16 + 8);
        send_frame(6'd16, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
        send_frame(6'd8, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 0, -1);
        send_frame(6'd32, 8'h96, 1'b1, 1'b1, 1'b1, 1'b0, 0, -1);

        for (int k = 0; k < 40; k++) begin
            logic [5:0] ps;
            logic [7:0] d;
            bit gl;
            ps = ps_tab[$urandom_range(2, 0)];
            d  = 8'($urandom);
            gl = ($urandom_range(9, 0) == 0);
            send_frame(ps, d, 1'($urandom), 1'($urandom), ($urandom_range(3, 0) == 0),
                       ($urandom_range(5, 0) != 0), gl ? int'($urandom_range(int'(ps) - 2, 1)) : 0, -1);
            idle(int'($urandom_range(2, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
